// File: rtl/fixed_2d_tile_transpose_pkg.sv
// Shared definitions for fill-then-drain matrix buffers.
package fixed_2d_tile_transpose_pkg;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } fill_drain_state_e;

  // Counter width that stays at least one bit for single-entry ranges.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/fixed_2d_tile_transpose_tile.sv
// In-tile transpose: a ROWS x COLS tile becomes a COLS x ROWS tile (pure wiring).
module fixed_tile_transpose #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic [ROWS*COLS-1:0][DATA_WIDTH-1:0] stored_tile,
  output logic [COLS*ROWS-1:0][DATA_WIDTH-1:0] transposed_tile
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign transposed_tile[c*ROWS+r] = stored_tile[r*COLS+c];
    end
  end

endmodule

// File: rtl/fixed_2d_tile_transpose.sv
// Buffers one IN_Y x W_Y matrix arriving row-block-major and re-emits it
// transposed, column-block-major, as UNROLL_W_Y x UNROLL_IN_Y tiles.
module fixed_2d_tile_transpose
  import fixed_2d_tile_transpose_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IN_Y        = 8,
  parameter int UNROLL_IN_Y = 4,
  parameter int W_Y         = 8,
  parameter int UNROLL_W_Y  = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [UNROLL_IN_Y*UNROLL_W_Y-1:0][DATA_WIDTH-1:0] data_in,
  input  logic                                             data_in_valid,
  output logic                                             data_in_ready,
  output logic [UNROLL_W_Y*UNROLL_IN_Y-1:0][DATA_WIDTH-1:0] data_out,
  output logic                                             data_out_valid,
  input  logic                                             data_out_ready
);

  localparam int ITER_IN_Y  = IN_Y / UNROLL_IN_Y;
  localparam int ITER_W_Y   = W_Y / UNROLL_W_Y;
  localparam int TILES      = ITER_IN_Y * ITER_W_Y;
  localparam int TILE_ELEMS = UNROLL_IN_Y * UNROLL_W_Y;
  localparam int CNT_W      = cnt_width(TILES);
  localparam int IY_W       = cnt_width(ITER_IN_Y);
  localparam int IW_W       = cnt_width(ITER_W_Y);

  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(TILES - 1);
  localparam logic [IY_W-1:0]  IY_LAST = IY_W'(ITER_IN_Y - 1);
  localparam logic [IW_W-1:0]  IW_LAST = IW_W'(ITER_W_Y - 1);

  if (((IN_Y % UNROLL_IN_Y) != 0) || ((W_Y % UNROLL_W_Y) != 0)) begin : g_illegal_tiling
    $error("fixed_2d_tile_transpose: IN_Y/W_Y must be multiples of UNROLL_IN_Y/UNROLL_W_Y");
  end

  fill_drain_state_e                       state_r;
  logic [CNT_W-1:0]                        wr_cnt_r;
  logic [IY_W-1:0]                         iy_rd_r;
  logic [IW_W-1:0]                         iw_rd_r;
  logic                                    in_ready_r;
  logic                                    out_valid_r;
  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0]   tile_mem_r [TILES];

  logic                                    wr_en_s;
  logic                                    rd_en_s;
  logic [CNT_W-1:0]                        rd_idx_s;
  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0]   rd_tile_s;

  assign wr_en_s        = data_in_valid & in_ready_r;
  assign rd_en_s        = out_valid_r & data_out_ready;
  assign data_in_ready  = in_ready_r;
  assign data_out_valid = out_valid_r;

  // FSM and counters; ready/valid are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= FILL;
      wr_cnt_r    <= '0;
      iy_rd_r     <= '0;
      iw_rd_r     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (wr_en_s) begin
            if (wr_cnt_r == WR_LAST) begin
              wr_cnt_r    <= '0;
              state_r     <= DRAIN;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              wr_cnt_r <= wr_cnt_r + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (rd_en_s) begin
            if (iy_rd_r == IY_LAST) begin
              iy_rd_r <= '0;
              if (iw_rd_r == IW_LAST) begin
                iw_rd_r     <= '0;
                state_r     <= FILL;
                in_ready_r  <= 1'b1;
                out_valid_r <= 1'b0;
              end else begin
                iw_rd_r <= iw_rd_r + IW_W'(1);
              end
            end else begin
              iy_rd_r <= iy_rd_r + IY_W'(1);
            end
          end
        end
        default: begin
          state_r     <= FILL;
          wr_cnt_r    <= '0;
          iy_rd_r     <= '0;
          iw_rd_r     <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Tile storage; contents are don't-care after reset so no reset term.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      tile_mem_r[wr_cnt_r] <= data_in;
    end
  end

  // Read address walks iy fastest so consecutive outputs share a column block.
  always_comb begin
    rd_idx_s  = CNT_W'(iy_rd_r) * CNT_W'(ITER_W_Y) + CNT_W'(iw_rd_r);
    rd_tile_s = tile_mem_r[rd_idx_s];
  end

  fixed_tile_transpose #(
    .DATA_WIDTH (DATA_WIDTH),
    .ROWS       (UNROLL_IN_Y),
    .COLS       (UNROLL_W_Y)
  ) u_tile_transpose (
    .stored_tile     (rd_tile_s),
    .transposed_tile (data_out)
  );

endmodule

// File: tb/tb_fixed_2d_tile_transpose.sv
// Scoreboard bench: 4x4 matrix in 2x2 tiles, plus a single-tile 2x3 instance.
module tb_fixed_2d_tile_transpose;

  localparam int DW  = 16;
  localparam int UIY = 2;
  localparam int UWY = 2;
  localparam int ITY = 2;
  localparam int ITW = 2;
  localparam int NT  = ITY * ITW;
  localparam int NE  = UIY * UWY;

  typedef logic [NE-1:0][DW-1:0] tile_t;
  typedef logic [5:0][DW-1:0]    tile2_t;

  logic   clk = 1'b0;
  logic   rst;
  tile_t  data_in, data_out;
  logic   data_in_valid, data_in_ready, data_out_valid, data_out_ready;
  tile2_t d_data_in, d_data_out;
  logic   d_in_valid, d_in_ready, d_out_valid, d_out_ready;

  int     checks   = 0;
  int     failures = 0;
  tile_t  exp_q[$];
  tile2_t exp2_q[$];

  always #5 clk = ~clk;

  fixed_2d_tile_transpose #(
    .DATA_WIDTH(DW), .IN_Y(4), .UNROLL_IN_Y(UIY), .W_Y(4), .UNROLL_W_Y(UWY)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
  );

  fixed_2d_tile_transpose #(
    .DATA_WIDTH(DW), .IN_Y(2), .UNROLL_IN_Y(2), .W_Y(3), .UNROLL_W_Y(3)
  ) dut_single (
    .clk(clk), .rst(rst),
    .data_in(d_data_in), .data_in_valid(d_in_valid), .data_in_ready(d_in_ready),
    .data_out(d_data_out), .data_out_valid(d_out_valid), .data_out_ready(d_out_ready)
  );

  function automatic logic [DW-1:0] elem(input int base, input int row, input int col);
    return DW'(base + row * 16 + col);
  endfunction

  // Input tile k: iy outer, iw inner; element r*UWY+c
  function automatic tile_t in_tile(input int base, input int k);
    tile_t t;
    int iy, iw;
    iy = k / ITW;
    iw = k % ITW;
    for (int r = 0; r < UIY; r++)
      for (int c = 0; c < UWY; c++)
        t[r*UWY+c] = elem(base, iy*UIY + r, iw*UWY + c);
    return t;
  endfunction

  // Output tile j: iw outer, iy inner; element c*UIY+r
  function automatic tile_t out_tile(input int base, input int j);
    tile_t t;
    int iy, iw;
    iw = j / ITY;
    iy = j % ITY;
    for (int r = 0; r < UIY; r++)
      for (int c = 0; c < UWY; c++)
        t[c*UIY+r] = elem(base, iy*UIY + r, iw*UWY + c);
    return t;
  endfunction

  task automatic fill_matrix(input int base, input int ntiles, input bit gaps, input bit expect_ready_now);
    if (ntiles == NT)
      for (int j = 0; j < NT; j++) exp_q.push_back(out_tile(base, j));
    for (int k = 0; k < ntiles; k++) begin
      bit sent = 1'b0;
      int tries = 0;
      while (!sent && tries < 200) begin
        @(negedge clk);
        if (k == 0 && tries == 0 && expect_ready_now) begin
          checks++;
          if (data_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL refill_ready: data_in_ready=%b expected 1", data_in_ready);
          end
        end
        checks++;
        if (data_out_valid !== 1'b0) begin
          failures++;
          $display("FAIL fill_out_valid: tile %0d data_out_valid=%b expected 0", k, data_out_valid);
        end
        data_in       = in_tile(base, k);
        data_in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        if (data_in_valid && data_in_ready) sent = 1'b1;
        tries++;
      end
      if (!sent) begin
        checks++;
        failures++;
        $display("FAIL fill_timeout: tile %0d not accepted, data_in_ready=%b expected 1", k, data_in_ready);
      end
    end
  endtask

  task automatic drain_matrix(input int nout, input bit stall);
    int    got = 0;
    int    cyc = 0;
    bit    holding = 1'b0;
    tile_t held, exp_t;
    while (got < nout && cyc < 200) begin
      @(negedge clk);
      if (cyc == 0) data_in_valid = 1'b0;
      checks++;
      if (data_out_valid !== 1'b1) begin
        failures++;
        $display("FAIL drain_valid: cycle %0d data_out_valid=%b expected 1", cyc, data_out_valid);
      end
      checks++;
      if (data_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL drain_in_ready: cycle %0d data_in_ready=%b expected 0", cyc, data_in_ready);
      end
      if (holding) begin
        checks++;
        if (data_out !== held) begin
          failures++;
          $display("FAIL stall_hold: data_out=%h expected %h", data_out, held);
        end
      end
      data_out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (data_out_ready && data_out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL drain_extra: data_out=%h expected no output", data_out);
        end else begin
          exp_t = exp_q.pop_front();
          if (data_out !== exp_t) begin
            failures++;
            $display("FAIL tile_data: out %0d data_out=%h expected %h", got, data_out, exp_t);
          end
        end
        got++;
        holding = 1'b0;
      end else begin
        holding = 1'b1;
        held    = data_out;
      end
      cyc++;
    end
    if (got < nout) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d tiles expected %0d", got, nout);
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (data_in_ready !== 1'b1 || data_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s: ready=%b valid=%b expected ready=1 valid=0", tag, data_in_ready, data_out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset_main");
    checks++;
    if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_single: ready=%b valid=%b expected ready=1 valid=0", d_in_ready, d_out_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    fill_matrix(32'h00, NT, 1'b0, 1'b0);
    drain_matrix(NT, 1'b0);
    @(negedge clk);
    check_idle("basic_return_fill");
  endtask

  task automatic test_backpressure();
    fill_matrix(32'h40, NT, 1'b0, 1'b0);
    drain_matrix(NT, 1'b1);
    @(negedge clk);
    check_idle("bp_return_fill");
  endtask

  task automatic test_input_gaps();
    fill_matrix(32'h00, NT, 1'b1, 1'b0);
    drain_matrix(NT, 1'b0);
  endtask

  task automatic test_back_to_back();
    fill_matrix(32'h00, NT, 1'b0, 1'b1);
    drain_matrix(NT, 1'b0);
    fill_matrix(32'h80, NT, 1'b0, 1'b1);
    drain_matrix(NT, 1'b0);
    @(negedge clk);
    check_idle("b2b_return_fill");
  endtask

  task automatic test_reset_mid_fill();
    fill_matrix(32'h55, 2, 1'b0, 1'b0);
    @(negedge clk);
    data_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_mid_fill");
    fill_matrix(32'h20, NT, 1'b0, 1'b0);
    drain_matrix(NT, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    fill_matrix(32'h60, NT, 1'b0, 1'b0);
    drain_matrix(2, 1'b0);
    @(negedge clk);
    data_out_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_mid_drain");
    fill_matrix(32'h10, NT, 1'b0, 1'b0);
    drain_matrix(NT, 1'b0);
  endtask

  task automatic test_degenerate();
    int     in_vals[6]  = '{1, 2, 3, 4, 5, 6};
    int     out_vals[6] = '{1, 4, 2, 5, 3, 6};
    tile2_t exp_t;
    for (int i = 0; i < 6; i++) begin
      d_data_in[i] = DW'(in_vals[i]);
      exp_t[i]     = DW'(out_vals[i]);
    end
    exp2_q.push_back(exp_t);
    @(negedge clk);
    checks++;
    if (d_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_in_ready: ready=%b expected 1", d_in_ready);
    end
    d_in_valid = 1'b1;
    @(negedge clk);
    d_in_valid  = 1'b0;
    d_out_ready = 1'b1;
    checks++;
    if (d_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_out_valid: valid=%b expected 1", d_out_valid);
    end
    exp_t = exp2_q.pop_front();
    checks++;
    if (d_data_out !== exp_t) begin
      failures++;
      $display("FAIL single_data: data_out=%h expected %h", d_data_out, exp_t);
    end
    @(negedge clk);
    d_out_ready = 1'b0;
    checks++;
    if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_return: ready=%b valid=%b expected ready=1 valid=0", d_in_ready, d_out_valid);
    end
  endtask

  initial begin
    rst            = 1'b1;
    data_in        = '0;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    d_data_in      = '0;
    d_in_valid     = 1'b0;
    d_out_ready    = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_input_gaps();
    test_back_to_back();
    test_reset_mid_fill();
    test_reset_mid_drain();
    test_degenerate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
